// File: rtl/apb_prot_filter_if.sv
// APB3/APB4 bus bundle used on both sides of the protection filter.
// A transfer completes in the cycle where psel & penable & pready are all high; pslverr/prdata are valid only then.
interface apb_prot_filter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [2:0]            pprot;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_prot_filter.sv
// APB protection filter: checks PPROT against a per-region policy, completes illegal
// transfers locally with PSLVERR, and logs the first violation plus a saturating count.
module apb_prot_filter #(
    parameter int                     ADDR_WIDTH  = 12,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS-1:0] REQ_PRIV    = 4'b1100,
    parameter logic [NUM_REGIONS-1:0] REQ_SECURE  = 4'b1000,
    parameter logic [NUM_REGIONS-1:0] NO_INSTR    = 4'b0010,
    parameter int                     CNT_WIDTH   = 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  enable,
    apb_prot_filter_if.slave      s_apb,
    apb_prot_filter_if.master     m_apb,
    input  logic                  vio_clr,
    output logic                  vio_valid,
    output logic [ADDR_WIDTH-1:0] vio_addr,
    output logic [2:0]            vio_prot,
    output logic                  vio_write,
    output logic [CNT_WIDTH-1:0]  vio_cnt,
    output logic                  irq,
    output logic [1:0]            dbg_state
);

    localparam int RW = $clog2(NUM_REGIONS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Only IDLE/ACCESS are ever registered: SETUP is recognised from the bus in the
    // same cycle so the decision can suppress M_PSEL before the peripheral sees it.
    state_t          state_q, state_d, phase;
    logic            blk_q;
    logic            blk;
    logic            viol;
    logic [RW-1:0]   region;

    assign region    = s_apb.paddr[ADDR_WIDTH-1 -: RW];
    assign dbg_state = phase;
    assign irq       = vio_valid;

    // State register
    always_ff @(posedge pclk) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        phase = IDLE;
        if (state_q == ACCESS)                  phase = ACCESS;
        else if (s_apb.psel && !s_apb.penable)  phase = SETUP;

        state_d = IDLE;
        case (phase)
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = s_apb.pready ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        viol = enable & ((REQ_PRIV[region]   & ~s_apb.pprot[0]) |
                         (REQ_SECURE[region] &  s_apb.pprot[1]) |
                         (NO_INSTR[region]   &  s_apb.pprot[2]));

        blk = 1'b0;
        if (phase == SETUP)       blk = viol;
        else if (phase == ACCESS) blk = blk_q;

        m_apb.psel    = s_apb.psel & ~blk;
        m_apb.penable = s_apb.penable & ~blk;
        m_apb.pwrite  = s_apb.pwrite;
        m_apb.paddr   = s_apb.paddr;
        m_apb.pwdata  = s_apb.pwdata;
        m_apb.pprot   = s_apb.pprot;

        s_apb.prdata  = m_apb.prdata;
        s_apb.pready  = m_apb.pready;
        s_apb.pslverr = 1'b0;
        if (phase == ACCESS) begin
            if (blk_q) begin
                s_apb.prdata  = '0;
                s_apb.pready  = 1'b1;
                s_apb.pslverr = 1'b1;
            end else begin
                s_apb.pslverr = m_apb.pslverr;
            end
        end
    end

    // Block decision is frozen at the setup edge so ENABLE changes wait for the next transfer.
    always_ff @(posedge pclk) begin
        if (preset) begin
            blk_q <= 1'b0;
        end else if (phase == SETUP) begin
            blk_q <= viol;
        end else if (phase == ACCESS && !s_apb.pready) begin
            blk_q <= blk_q;
        end else begin
            blk_q <= 1'b0;
        end
    end

    // Violation log: a clear coinciding with a new event leaves only the new event recorded.
    always_ff @(posedge pclk) begin
        if (preset) begin
            vio_valid <= 1'b0;
            vio_addr  <= '0;
            vio_prot  <= '0;
            vio_write <= 1'b0;
            vio_cnt   <= '0;
        end else if (phase == SETUP && viol) begin
            if (vio_clr || !vio_valid) begin
                vio_valid <= 1'b1;
                vio_addr  <= s_apb.paddr;
                vio_prot  <= s_apb.pprot;
                vio_write <= s_apb.pwrite;
            end
            if (vio_clr)                            vio_cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            else if (vio_cnt != {CNT_WIDTH{1'b1}})  vio_cnt <= vio_cnt + 1'b1;
        end else if (vio_clr) begin
            vio_valid <= 1'b0;
            vio_addr  <= '0;
            vio_prot  <= '0;
            vio_write <= 1'b0;
            vio_cnt   <= '0;
        end
    end

endmodule

// File: tb/tb_apb_prot_filter.sv
// Directed bench for apb_prot_filter: transfers push their expected upstream response,
// a negedge monitor pops and compares at every completion; log outputs are checked directly.
module tb_apb_prot_filter;

    localparam int          AW        = 12;
    localparam int          DW        = 32;
    localparam int          RSPW      = 1 + 4 + 1 + DW;
    localparam logic [31:0] SLV_RDATA = 32'hA5A5_0001;

    logic          pclk = 1'b0;
    logic          preset;
    logic          enable;
    logic          vio_clr;
    logic          vio_valid;
    logic [AW-1:0] vio_addr;
    logic [2:0]    vio_prot;
    logic          vio_write;
    logic [7:0]    vio_cnt;
    logic          irq;
    logic [1:0]    dbg_state;

    apb_prot_filter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();
    apb_prot_filter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();

    apb_prot_filter dut (
        .pclk      (pclk),
        .preset    (preset),
        .enable    (enable),
        .s_apb     (s_bus),
        .m_apb     (m_bus),
        .vio_clr   (vio_clr),
        .vio_valid (vio_valid),
        .vio_addr  (vio_addr),
        .vio_prot  (vio_prot),
        .vio_write (vio_write),
        .vio_cnt   (vio_cnt),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 pclk = ~pclk;

    // Peripheral model: fixed wait states, constant read data, optional error.
    int   slv_waits;
    int   slv_cnt;
    logic slv_err;

    assign m_bus.prdata  = SLV_RDATA;
    assign m_bus.pready  = m_bus.psel & m_bus.penable & (slv_cnt == slv_waits);
    assign m_bus.pslverr = slv_err;

    always @(posedge pclk) begin
        if (m_bus.psel && m_bus.penable && !m_bus.pready) slv_cnt <= slv_cnt + 1;
        else                                              slv_cnt <= 0;
    end

    // Scoreboard
    logic [RSPW-1:0] exp_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    logic            mon_mute = 1'b0;
    logic            touched  = 1'b0;
    logic [3:0]      waits    = '0;

    function automatic logic [RSPW-1:0] rsp(input logic t, input logic [3:0] w,
                                            input logic e, input logic [31:0] d);
        return {t, w, e, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (preset || mon_mute) begin
            touched = 1'b0;
            waits   = '0;
        end else if (s_bus.psel) begin
            if (m_bus.psel) touched = 1'b1;
            if (s_bus.penable) begin
                if (!s_bus.pready) begin
                    waits = waits + 1'b1;
                end else begin
                    logic [RSPW-1:0] got, exp;
                    got = {touched, waits, s_bus.pslverr, s_bus.prdata};
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got %0h expected no transfer", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            n_fail++;
                            $display("FAIL sb_rsp: got t=%0b w=%0d e=%0b d=%0h expected t=%0b w=%0d e=%0b d=%0h",
                                     got[37], got[36:33], got[32], got[31:0],
                                     exp[37], exp[36:33], exp[32], exp[31:0]);
                        end
                    end
                    touched = 1'b0;
                    waits   = '0;
                end
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [2:0] prot,
                            input logic clr, input logic drop_en, input logic [RSPW-1:0] exp);
        int n;
        exp_q.push_back(exp);
        s_bus.psel    = 1'b1;
        s_bus.penable = 1'b0;
        s_bus.pwrite  = wr;
        s_bus.paddr   = addr;
        s_bus.pprot   = prot;
        s_bus.pwdata  = $urandom;
        vio_clr       = clr;
        @(posedge pclk); #1;
        vio_clr       = 1'b0;
        s_bus.penable = 1'b1;
        if (drop_en) enable = 1'b0;
        n = 0;
        @(negedge pclk);
        while (!s_bus.pready && n < 20) begin
            @(negedge pclk);
            n++;
        end
        if (!s_bus.pready) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_timeout: got no pready after %0d cycles expected completion", n);
        end
        @(posedge pclk); #1;
        s_bus.psel    = 1'b0;
        s_bus.penable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        preset        = 1'b1;
        enable        = 1'b1;
        vio_clr       = 1'b0;
        slv_waits     = 2;
        slv_err       = 1'b0;
        s_bus.psel    = 1'b0;
        s_bus.penable = 1'b0;
        s_bus.pwrite  = 1'b0;
        s_bus.paddr   = '0;
        s_bus.pwdata  = '0;
        s_bus.pprot   = '0;
        idle(3);
        preset = 1'b0;
        @(negedge pclk);
        check("rst_vio_valid", vio_valid, 0);
        check("rst_vio_cnt", vio_cnt, 0);
        check("rst_irq", irq, 0);
        check("rst_vio_addr", vio_addr, 0);
        check("rst_s_pslverr", s_bus.pslverr, 0);
        idle(1);

        // Legal unprivileged write to region 0 with two wait states
        apb_xfer(1'b1, 12'h010, 3'b000, 1'b0, 1'b0, rsp(1'b1, 4'd2, 1'b0, SLV_RDATA));
        @(negedge pclk);
        check("legal_cnt", vio_cnt, 0);
        check("legal_valid", vio_valid, 0);
        idle(1);

        // Privilege violation in region 2
        slv_waits = 1;
        apb_xfer(1'b0, 12'h800, 3'b000, 1'b0, 1'b0, rsp(1'b0, 4'd0, 1'b1, 32'h0));
        @(negedge pclk);
        check("priv_valid", vio_valid, 1);
        check("priv_addr", vio_addr, 12'h800);
        check("priv_prot", vio_prot, 3'b000);
        check("priv_write", vio_write, 0);
        check("priv_irq", irq, 1);
        check("priv_cnt", vio_cnt, 1);

        // Privileged read to region 2 passes
        apb_xfer(1'b0, 12'h804, 3'b001, 1'b0, 1'b0, rsp(1'b1, 4'd1, 1'b0, SLV_RDATA));
        // Back-to-back: non-secure into region 3, instruction fetch into region 1
        apb_xfer(1'b1, 12'hC04, 3'b011, 1'b0, 1'b0, rsp(1'b0, 4'd0, 1'b1, 32'h0));
        apb_xfer(1'b1, 12'h404, 3'b101, 1'b0, 1'b0, rsp(1'b0, 4'd0, 1'b1, 32'h0));
        @(negedge pclk);
        check("multi_addr", vio_addr, 12'h800);
        check("multi_write", vio_write, 0);
        check("multi_cnt", vio_cnt, 3);

        // Saturation
        for (int i = 0; i < 300; i++)
            apb_xfer(1'b1, 12'h800, 3'b000, 1'b0, 1'b0, rsp(1'b0, 4'd0, 1'b1, 32'h0));
        @(negedge pclk);
        check("sat_cnt", vio_cnt, 255);

        // Clear colliding with a new event
        apb_xfer(1'b1, 12'hC00, 3'b010, 1'b1, 1'b0, rsp(1'b0, 4'd0, 1'b1, 32'h0));
        @(negedge pclk);
        check("coll_valid", vio_valid, 1);
        check("coll_addr", vio_addr, 12'hC00);
        check("coll_prot", vio_prot, 3'b010);
        check("coll_write", vio_write, 1);
        check("coll_cnt", vio_cnt, 1);

        // Plain clear
        idle(1);
        vio_clr = 1'b1;
        idle(1);
        vio_clr = 1'b0;
        @(negedge pclk);
        check("clr_valid", vio_valid, 0);
        check("clr_cnt", vio_cnt, 0);
        check("clr_irq", irq, 0);

        // Checks disabled: illegal access reaches the slave and its error propagates
        enable  = 1'b0;
        slv_err = 1'b1;
        apb_xfer(1'b0, 12'hC00, 3'b110, 1'b0, 1'b0, rsp(1'b1, 4'd1, 1'b1, SLV_RDATA));
        slv_err = 1'b0;
        @(negedge pclk);
        check("dis_valid", vio_valid, 0);
        check("dis_cnt", vio_cnt, 0);

        // ENABLE dropped during ACCESS of a blocked transfer
        enable = 1'b1;
        apb_xfer(1'b0, 12'h800, 3'b000, 1'b0, 1'b1, rsp(1'b0, 4'd0, 1'b1, 32'h0));
        enable = 1'b1;
        @(negedge pclk);
        check("drop_en_cnt", vio_cnt, 1);
        check("drop_en_addr", vio_addr, 12'h800);

        // Reset during ACCESS of a blocked transfer
        idle(1);
        mon_mute      = 1'b1;
        s_bus.psel    = 1'b1;
        s_bus.penable = 1'b0;
        s_bus.pwrite  = 1'b0;
        s_bus.paddr   = 12'h800;
        s_bus.pprot   = 3'b000;
        @(posedge pclk); #1;
        s_bus.penable = 1'b1;
        preset        = 1'b1;
        @(negedge pclk);
        check("rstmid_blk_slverr", s_bus.pslverr, 1);
        check("rstmid_blk_msel", m_bus.psel, 0);
        @(posedge pclk); #1;
        preset = 1'b0;
        @(negedge pclk);
        check("rstmid_valid", vio_valid, 0);
        check("rstmid_cnt", vio_cnt, 0);
        check("rstmid_addr", vio_addr, 0);
        check("rstmid_prot", vio_prot, 0);
        check("rstmid_write", vio_write, 0);
        check("rstmid_irq", irq, 0);
        check("rstmid_s_pslverr", s_bus.pslverr, 0);
        check("rstmid_passthru_msel", m_bus.psel, 1);
        @(posedge pclk); #1;
        s_bus.psel    = 1'b0;
        s_bus.penable = 1'b0;
        idle(1);
        mon_mute = 1'b0;
        apb_xfer(1'b1, 12'h020, 3'b000, 1'b0, 1'b0, rsp(1'b1, 4'd1, 1'b0, SLV_RDATA));
        @(negedge pclk);
        check("post_rst_cnt", vio_cnt, 0);

        idle(3);
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_prot_filter.md
Name: apb_prot_filter

Overview:
- Parametrised APB3/APB4 protection filter. It sits between the APB bridge (upstream, S_ side) and a peripheral such as the SPI slave (downstream, M_ side).
- Each access is checked by decoding PPROT against a per-region policy selected by the upper address bits.
- Illegal transfers are kept from reaching the peripheral. The filter completes them itself with PSLVERR.
- The first violation is logged, all violations are counted, and an interrupt is raised.

Parameters:
- ADDR_WIDTH, 12, APB address width.
- DATA_WIDTH, 32, APB data width.
- NUM_REGIONS, 4, number of policy regions; power of 2, ≥2. Region index = PADDR[ADDR_WIDTH-1 -: clog2(NUM_REGIONS)].
- REQ_PRIV, 4'b1100, per-region bit; 1 = PPROT[0] must be 1 (privileged).
- REQ_SECURE, 4'b1000, per-region bit; 1 = PPROT[1] must be 0 (secure).
- NO_INSTR, 4'b0010, per-region bit; 1 = PPROT[2] must be 0 (data access only).
- CNT_WIDTH, 8, violation counter width; counter saturates.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- ENABLE  in  1  1 = checks active; 0 = pure pass-through, no logging
- S_PSEL, S_PENABLE, S_PWRITE  in  1 each  upstream APB control
- S_PADDR  in  ADDR_WIDTH  upstream address
- S_PWDATA  in  DATA_WIDTH  upstream write data
- S_PPROT  in  3  upstream protection
- S_PRDATA  out  DATA_WIDTH  read data to upstream
- S_PREADY, S_PSLVERR  out  1 each  response to upstream
- M_PSEL, M_PENABLE, M_PWRITE  out  1 each  downstream control
- M_PADDR  out  ADDR_WIDTH; M_PWDATA  out  DATA_WIDTH; M_PPROT  out  3  forwarded from upstream
- M_PRDATA  in  DATA_WIDTH; M_PREADY, M_PSLVERR  in  1 each  downstream response
- VIO_CLR  in  1  one-cycle pulse; clears log and counter
- VIO_VALID  out  1  a violation has been logged
- VIO_ADDR  out  ADDR_WIDTH; VIO_PROT  out  3; VIO_WRITE  out  1  details of the first logged violation
- VIO_CNT  out  CNT_WIDTH  saturating count of blocked transfers
- IRQ  out  1  equals VIO_VALID

Behaviour:
- Reset (PRESET=1 at PCLK edge):
  - State = IDLE; blk_q=0; VIO_VALID=0; VIO_ADDR=0; VIO_PROT=0; VIO_WRITE=0; VIO_CNT=0.
  - Combinational outputs follow the upstream inputs with blk=0.
  - A reset in mid-transfer abandons the block decision, so the upstream master sees pass-through behaviour on the next cycle.
- Tracking FSM:
  - IDLE→SETUP when S_PSEL & ~S_PENABLE.
  - SETUP→ACCESS unconditionally.
  - ACCESS stays while ~S_PREADY.
  - ACCESS→SETUP when S_PREADY and a new setup is present; ACCESS→IDLE when S_PREADY and ~S_PSEL.
- Check, evaluated combinationally in SETUP, with r = region index:
  - viol = ENABLE & ((REQ_PRIV[r] & ~PPROT[0]) | (REQ_SECURE[r] & PPROT[1]) | (NO_INSTR[r] & PPROT[2])).
  - blk_q <= viol on the SETUP edge. blk_q is held through ACCESS and cleared on leaving ACCESS.
- Blocking signal: blk = viol in SETUP, blk_q in ACCESS, 0 otherwise.
- Downstream outputs:
  - M_PSEL = S_PSEL & ~blk; M_PENABLE = S_PENABLE & ~blk.
  - Other M_ outputs are direct copies of the upstream signals.
  - A blocked transfer never asserts M_PSEL.
- Upstream response:
  - blk=0: S_PRDATA/S_PREADY/S_PSLVERR = M_ values.
  - ACCESS with blk_q=1: S_PREADY=1, S_PSLVERR=1, S_PRDATA=0. The transfer completes with zero wait states and has no side effect on the peripheral.
  - Outside ACCESS: S_PSLVERR=0.
- Logging, applied on the SETUP edge of each blocked transfer (once per transfer, never again in ACCESS wait cycles):
  - If VIO_VALID=0, capture PADDR, PPROT and PWRITE and set VIO_VALID.
  - If VIO_VALID=1, existing capture fields are not overwritten.
  - VIO_CNT increments by 1 and saturates at 2^CNT_WIDTH-1.
- VIO_CLR:
  - Clears VIO_VALID, VIO_CNT and the capture fields.
  - VIO_CLR in the same cycle as a new logging event: the clear takes priority, then the new event is applied. Result: VIO_VALID=1, new fields captured, VIO_CNT=1.
- ENABLE change mid-transfer: takes effect only at the next SETUP, because blk_q is held.
- Back-to-back transfers (ACCESS→SETUP) are each evaluated independently.

Test Plan:
- Legal access, unprivileged, in region 0: write PADDR=0x010, PPROT=3'b000, M_PREADY stalls 2 cycles → M_PSEL/M_PENABLE mirror upstream, S_PREADY asserts after 2 wait cycles, S_PSLVERR=0, VIO_CNT=0.
- Privilege violation: read PADDR=0x800 (region 2), PPROT=3'b000 → M_PSEL stays 0, S_PREADY=1/S_PSLVERR=1/S_PRDATA=0 in the first ACCESS cycle, VIO_VALID=1, VIO_ADDR=0x800, VIO_PROT=0, VIO_WRITE=0, IRQ=1, VIO_CNT=1.
- Multiple violations: in addition to the above, write PADDR=0xC04 with PPROT=3'b011 (non-secure into region 3), then PADDR=0x404 with PPROT=3'b101 (instruction into region 1) → VIO_ADDR remains 0x800, VIO_CNT=3. Repeat blocked accesses 300 times with CNT_WIDTH=8 → VIO_CNT saturates at 255.
- Clear/event collision: VIO_CLR pulsed on the SETUP edge of a blocked write to 0xC00 with PPROT=3'b010 → VIO_VALID=1, VIO_ADDR=0xC00, VIO_PROT=3'b010, VIO_WRITE=1, VIO_CNT=1.
- ENABLE=0 with an otherwise illegal access to 0xC00, PPROT=3'b110 → passes to the slave, M_PSLVERR propagates, no logging. Also drop ENABLE during ACCESS of a blocked transfer → that transfer remains blocked.
- PRESET asserted during ACCESS of a blocked transfer → next cycle all log outputs=0, S_PSLVERR=0, and the following legal transfer passes normally.
